// File: rtl/reg_file_sb.sv
// Multi-port register file with write bypass, a pending-write scoreboard
// and a handshaked dump engine that streams every register out.
module reg_file_sb #(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned DEPTH  = 32,
    parameter int unsigned AW     = $clog2(DEPTH),
    parameter int unsigned NUM_RD = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_RD*AW-1:0]     ra,
    output logic [NUM_RD*XLEN-1:0]   rd,
    output logic [NUM_RD-1:0]        rd_busy,
    input  logic                     we,
    input  logic [AW-1:0]            wa,
    input  logic [XLEN-1:0]          wd,
    input  logic                     iss_valid,
    input  logic [AW-1:0]            iss_addr,
    input  logic                     dump_req,
    output logic                     dump_valid,
    input  logic                     dump_ready,
    output logic [AW-1:0]            dump_idx,
    output logic [XLEN-1:0]          dump_data,
    output logic                     dump_done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DUMP = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state_q;
    state_t            state_d;
    logic [AW-1:0]     idx_q;
    logic [AW-1:0]     idx_d;
    logic              valid_q;
    logic              done_q;
    logic [XLEN-1:0]   regs [DEPTH];
    logic [DEPTH-1:0]  busy;
    logic              wr_en;

    assign wr_en = we && (wa != '0);

    // Register storage; address 0 is never written so it stays 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_en) begin
            regs[wa] <= wd;
        end
    end

    // Scoreboard: the issue set is ordered after the writeback clear so it wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy <= '0;
        end else begin
            if (wr_en) begin
                busy[wa] <= 1'b0;
            end
            if (iss_valid && (iss_addr != '0)) begin
                busy[iss_addr] <= 1'b1;
            end
        end
    end

    // Combinational read ports with same-cycle writeback bypass.
    for (genvar g = 0; g < NUM_RD; g++) begin : g_rd
        logic [AW-1:0] addr;
        logic          hit;

        assign addr = ra[g*AW +: AW];
        assign hit  = we && (wa == addr);
        assign rd[g*XLEN +: XLEN] = (addr == '0) ? '0 : (hit ? wd : regs[addr]);
        assign rd_busy[g] = (addr != '0) && busy[addr] && !hit;
    end

    // Dump FSM next-state logic.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        case (state_q)
            IDLE: begin
                if (dump_req) begin
                    state_d = DUMP;
                    idx_d   = '0;
                end
            end
            DUMP: begin
                if (dump_ready) begin
                    if (idx_q == AW'(DEPTH - 1)) begin
                        state_d = DONE;
                    end else begin
                        idx_d = idx_q + AW'(1);
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
                idx_d   = '0;
            end
            default: begin
                state_d = IDLE;
                idx_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            valid_q <= (state_d == DUMP);
            done_q  <= (state_d == DONE);
        end
    end

    // Raw stored value, so a write during a stalled beat shows up next cycle.
    assign dump_valid = valid_q;
    assign dump_done  = done_q;
    assign dump_idx   = idx_q;
    assign dump_data  = regs[idx_q];

endmodule
